// File: rtl/onehot_pkg.sv
// Shared constants and FSM encodings for the one-hot decoder.
// Scan support is built only when DECODER_SCAN_EN is defined.
package onehot_pkg;

    localparam int unsigned ONEHOT_DEFAULT_WIDTH = 32'd8;
    localparam int unsigned BOARD_CLK_HZ         = 32'd50_000_000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HOLD = 2'd1;
    localparam state_t ST_SCAN = 2'd2;

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Load/enable/output bundle of the one-hot decoder.
// i_scan/i_dir exist only when DECODER_SCAN_EN is defined.
interface onehot_decoder_seq_if
    import onehot_pkg::*;
#(
    parameter int ONEHOT_WIDTH = ONEHOT_DEFAULT_WIDTH
);
    localparam int BIN_WIDTH = $clog2(ONEHOT_WIDTH);

    logic [BIN_WIDTH-1:0]    i_bin;
    logic                    i_load;
    logic                    i_en;
`ifdef DECODER_SCAN_EN
    logic                    i_scan;
    logic                    i_dir;
`endif
    logic [ONEHOT_WIDTH-1:0] o_one_hot;
    logic                    o_active;
    logic [BIN_WIDTH-1:0]    o_bin;
    logic                    o_err;

`ifdef DECODER_SCAN_EN
    modport master (output i_bin, i_load, i_en, i_scan, i_dir,
                    input  o_one_hot, o_active, o_bin, o_err);
    modport slave  (input  i_bin, i_load, i_en, i_scan, i_dir,
                    output o_one_hot, o_active, o_bin, o_err);
`else
    modport master (output i_bin, i_load, i_en,
                    input  o_one_hot, o_active, o_bin, o_err);
    modport slave  (input  i_bin, i_load, i_en,
                    output o_one_hot, o_active, o_bin, o_err);
`endif

endinterface

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: o_tick marks the last clock of every TICK_DIV period.
// Built only when DECODER_SCAN_EN is defined.
`ifdef DECODER_SCAN_EN
module tick_prescaler
    import onehot_pkg::*;
#(
    parameter int TICK_DIV = BOARD_CLK_HZ
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A clear outranks a tick so a reload restarts the full period.
    assign o_tick = i_run & ~i_clr & (cnt_q == CNT_LAST);

    // Next count: clear, wrap at the end of the period, or advance while running.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with load/hold and output enable.
// DECODER_SCAN_EN adds the SCAN state that auto-steps the index every TICK_DIV clocks.
module onehot_decoder_seq
    import onehot_pkg::*;
#(
    parameter int ONEHOT_WIDTH = ONEHOT_DEFAULT_WIDTH,
    parameter int TICK_DIV     = BOARD_CLK_HZ
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    onehot_decoder_seq_if.slave  bus
);
    localparam int BIN_WIDTH = $clog2(ONEHOT_WIDTH);
    localparam logic [BIN_WIDTH:0]      WIDTH_L  = (BIN_WIDTH + 1)'(ONEHOT_WIDTH);
    localparam logic [ONEHOT_WIDTH-1:0] OH_ONE   = ONEHOT_WIDTH'(1);

    if ((ONEHOT_WIDTH < 2) || (TICK_DIV < 1)) begin : g_param_check
        $error("onehot_decoder_seq: ONEHOT_WIDTH must be >= 2 and TICK_DIV >= 1");
    end

    state_t                  state_q, state_d;
    logic [BIN_WIDTH-1:0]    idx_q, idx_d;
    logic [ONEHOT_WIDTH-1:0] one_hot_q, one_hot_d;
    logic                    active_q, active_d;
    logic                    err_q, err_d;
    logic                    in_range_s;
    logic                    load_ok_s;

    // Out-of-range codes only exist when ONEHOT_WIDTH is not a power of two.
    assign in_range_s = ({1'b0, bus.i_bin} < WIDTH_L);
    assign load_ok_s  = bus.i_load & in_range_s;

`ifdef DECODER_SCAN_EN
    localparam logic [BIN_WIDTH-1:0] IDX_LAST = BIN_WIDTH'(ONEHOT_WIDTH - 1);
    localparam logic [BIN_WIDTH-1:0] IDX_ONE  = BIN_WIDTH'(1);

    logic run_s;
    logic clr_s;
    logic tick_s;

    assign run_s = (state_q == ST_SCAN);
    assign clr_s = load_ok_s | (run_s & ~bus.i_scan);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (clr_s),
        .i_run  (run_s),
        .o_tick (tick_s)
    );
`endif

    // FSM next state; IDLE is left only by a valid load and re-entered only by reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_ok_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
`ifdef DECODER_SCAN_EN
                if (bus.i_scan) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_HOLD;
                end
`else
                state_d = ST_HOLD;
`endif
            end
`ifdef DECODER_SCAN_EN
            ST_SCAN: begin
                if (bus.i_scan) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Index update: a valid load wins over a scan step arriving in the same cycle.
    always_comb begin
        idx_d = idx_q;
        if (load_ok_s) begin
            idx_d = bus.i_bin;
`ifdef DECODER_SCAN_EN
        end else if (tick_s) begin
            if (bus.i_dir) begin
                idx_d = (idx_q == '0) ? IDX_LAST : (idx_q - IDX_ONE);
            end else begin
                idx_d = (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_ONE);
            end
`endif
        end else begin
            idx_d = idx_q;
        end
    end

    // Output next values derived from the next state so a load shows one clock later.
    always_comb begin
        one_hot_d = '0;
        if (bus.i_en && (state_d != ST_IDLE)) begin
            one_hot_d = OH_ONE << idx_d;
        end else begin
            one_hot_d = '0;
        end
        active_d = |one_hot_d;
        err_d    = bus.i_load & ~in_range_s;
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            one_hot_q <= '0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            one_hot_q <= one_hot_d;
            active_q  <= active_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_one_hot = one_hot_q;
    assign bus.o_active  = active_q;
    assign bus.o_bin     = idx_q;
    assign bus.o_err     = err_q;

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Registered binary-to-one-hot decoder with load/hold and an optional auto-scan sequencer: the inverse of the switch-driven priority encoder path. It takes a binary index, for example from switches or a counter. It drives a one-hot LED bar on the DE10-Lite board (LEDR). It also returns the held index so a `dec_7seg` instance can display it.

## Interface
- `ONEHOT_WIDTH`, default 8: one-hot output width, ≥2; not required to be a power of two. `BIN_WIDTH` = `$clog2(ONEHOT_WIDTH)` is a derived localparam.
- `TICK_DIV`, default 50_000_000: scan step period in clocks (1 Hz at 50 MHz); ≥1.
- `i_clk`  in  1  system clock, single clock domain.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_bin`  in  BIN_WIDTH  index to load.
- `i_load`  in  1  one-cycle load strobe; a level is treated as a load every cycle.
- `i_en`  in  1  output enable; gates `o_one_hot`/`o_active` only, state is kept.
- `i_scan`  in  1  auto-step enable (present only with `DECODER_SCAN_EN`).
- `i_dir`  in  1  scan direction, 0 = up, 1 = down (present only with `DECODER_SCAN_EN`).
- `o_one_hot`  out  ONEHOT_WIDTH  registered one-hot of held index, else all-zero.
- `o_active`  out  1  registered; 1 when `o_one_hot` is non-zero.
- `o_bin`  out  BIN_WIDTH  registered held index.
- `o_err`  out  1  one-cycle pulse when a load is rejected as out-of-range.

## Operation
- State: index register `idx`, prescaler `cnt`, and an FSM with states IDLE, HOLD and SCAN.
- Reset values: `idx`=0, `cnt`=0, state IDLE; all outputs are 0.
- IDLE: nothing is loaded and `o_one_hot`=0. A valid load moves the FSM to HOLD.
- HOLD: shows `idx`.
- HOLD → SCAN when `i_scan`=1.
- SCAN → HOLD when `i_scan`=0. `cnt` is cleared on the transition.
- There is no path back to IDLE except `i_rst`.
- Valid load (`i_load`=1 and `i_bin` < ONEHOT_WIDTH): `idx` ← `i_bin`, `cnt` ← 0. Allowed in every state.
- Out-of-range load:
  - `idx` and the FSM state are unchanged.
  - `o_err`=1 for one cycle.
  - Only reachable when ONEHOT_WIDTH is not a power of two.
- SCAN:
  - `cnt` counts 0..TICK_DIV-1; a tick occurs on the cycle `cnt`=TICK_DIV-1, and `cnt` then wraps to 0.
  - On a tick, `idx` steps by ±1 modulo ONEHOT_WIDTH.
  - Up wraps ONEHOT_WIDTH-1 → 0; down wraps 0 → ONEHOT_WIDTH-1.
- Simultaneous load and tick: the load wins and the tick is discarded. `cnt` restarts from 0.
- A change of `i_dir` mid-period takes effect at the next tick; `cnt` is not cleared.
- `i_en`=0: `o_one_hot`=0 and `o_active`=0. `o_bin` keeps tracking `idx`, and the prescaler and stepping continue.
- Output invariant: `o_one_hot` is exactly zero or has exactly one bit set. `o_active` is the OR of its bits.

## Timing
- All outputs are registered; there is no combinational input → output path.
- Load latency: a load sampled at edge N is visible on `o_bin`/`o_one_hot`/`o_active` right after edge N. This is 1 clock from strobe to output.
- `o_err` is asserted for the cycle right after the rejecting edge.
- `i_en` affects outputs after the next edge (1 clock).
- Scan step period is exactly TICK_DIV clocks, starting TICK_DIV clocks after entering SCAN or after the last load.
- `i_rst` has priority over everything. Asserting it mid-scan gives all-zero outputs after that edge.

## Configuration
- Macro: `DECODER_SCAN_EN`.
- Defined: the `i_scan`/`i_dir` ports, the prescaler and the SCAN state are built as described.
- Undefined:
  - No `i_scan`/`i_dir` ports and no prescaler logic; `TICK_DIV` is unused.
  - The FSM has only IDLE and HOLD.
  - The block becomes a pure registered load/hold decoder with identical load, enable and error behaviour.

## Structure
- Shared package `onehot_pkg`:
  - FSM state typedef and encodings (IDLE=0, HOLD=1, SCAN=2).
  - Default width constant (8).
  - Constant for the board clock frequency (50_000_000).
- Sub-module `tick_prescaler`:
  - Parameter `TICK_DIV`.
  - Ports `i_clk`, `i_rst`, `i_clr` (sync clear) and `i_run`; output `o_tick`.
  - Instantiated only under `DECODER_SCAN_EN`.
- The top-level board wrapper pairs `o_bin` with `dec_7seg` and drives `o_one_hot` to LEDR.

## Test plan
Bench parameters: ONEHOT_WIDTH=8, TICK_DIV=4.
- Reset → `o_one_hot`=8'h00, `o_active`=0, `o_bin`=0, `o_err`=0; no change over 20 idle cycles.
- Load `i_bin`=5 with `i_en`=1 → next cycle `o_one_hot`=8'h20, `o_active`=1, `o_bin`=5. Then `i_en`=0 → 8'h00 / 0 one cycle later with `o_bin` still 5.
- Load 6, then `i_scan`=1, `i_dir`=0 → 8'h40, then every 4 clocks 8'h80, 8'h01 (wrap), 8'h02. Then `i_dir`=1 → 8'h01, 8'h80.
- During SCAN, load 3 on the same cycle as a tick → `o_bin`=3, no step applied. The next step to 4 occurs exactly 4 clocks later.
- Separate instance with ONEHOT_WIDTH=6: load `i_bin`=7 → `o_err` pulses 1 cycle, `o_bin`/`o_one_hot` unchanged. Scan up from 5 wraps to 0 (6'h20 → 6'h01).
- Assert `i_rst` mid-scan at index 4 → all outputs 0 after the edge. A scan does not resume until a new load, even with `i_scan` held at 1.
